// File: rtl/pe_eject_buf.sv
// pe_eject_buf: ejection stage after the 2-VC PE arbiter/mux.
// Accepts flits from the arbiter-selected VC and queues them, tagged with
// their VC id, in a small FIFO. Delivers them to the PE over valid/ready and
// returns one credit per dequeued flit to the VC it came from.
// A packet-contiguity checker raises a sticky pkt_err on protocol violations.
// Optional feature: define PE_EJECT_BYPASS_EN for a zero-latency path when
// the FIFO is empty and the PE is ready.
module pe_eject_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [1:0]        sel,
  input  logic [DATA_W+1:0] in_flit0,
  input  logic              in_valid0,
  input  logic [DATA_W+1:0] in_flit1,
  input  logic              in_valid1,
  output logic [1:0]        in_ready,
  output logic [DATA_W+1:0] out_flit,
  output logic              out_vc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        credit,
  output logic              pkt_err
);

  localparam int FW = DATA_W + 2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    T_BODY   = 2'b00,
    T_HEAD   = 2'b01,
    T_TAIL   = 2'b10,
    T_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } pkt_state_e;

  // FIFO storage: {vc, flit} per entry
  logic [FW:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Packet checker state
  pkt_state_e state_q;
  logic       cur_vc_q;
  logic       pkt_err_q;

  // Datapath / handshake nets
  logic          full;
  logic          empty;
  logic          sel_conflict;
  logic          acc_vc;
  logic [FW-1:0] acc_flit;
  flit_type_e    acc_type;
  logic          enq;
  logic          deq;
  logic          bypass_take;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW:0]   head_entry;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign sel_conflict = &sel;

  // Selected-VC flit; with one-hot sel, sel[1] is the VC id
  assign acc_vc   = sel[1];
  assign acc_flit = sel[1] ? in_flit1 : in_flit0;
  assign acc_type = flit_type_e'(acc_flit[FW-1:DATA_W]);

  // Accept only with a legal one-hot select, room in the FIFO and not in reset
  assign in_ready = (rst_ || sel_conflict || full) ? 2'b00 : sel;
  assign enq      = |(in_ready & {in_valid1, in_valid0});

`ifdef PE_EJECT_BYPASS_EN
  assign bypass_take = empty & out_ready & enq;
`else
  assign bypass_take = 1'b0;
`endif

  assign head_entry = mem_q[rd_ptr_q];

  // Bypassed flit overrides the (empty) FIFO head on the output port
  assign out_flit  = bypass_take ? acc_flit : head_entry[FW-1:0];
  assign out_vc    = bypass_take ? acc_vc   : head_entry[FW];
  assign out_valid = ~rst_ & (~empty | bypass_take);

  assign deq     = out_valid & out_ready;
  assign fifo_wr = enq & ~bypass_take;
  assign fifo_rd = deq & ~bypass_take;

  // Credit goes back to the VC of the flit leaving this cycle
  assign credit = deq ? (out_vc ? 2'b10 : 2'b01) : 2'b00;

  assign pkt_err = pkt_err_q;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards buffered flits
  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO entry write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {acc_vc, acc_flit};
    end
  end

  // Packet contiguity checker over accepted flits, sticky error flag
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= S_IDLE;
      cur_vc_q  <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      if (sel_conflict) begin
        pkt_err_q <= 1'b1;
      end
      if (enq) begin
        unique case (state_q)
          S_IDLE: begin
            unique case (acc_type)
              T_HEAD: begin
                state_q  <= S_PKT;
                cur_vc_q <= acc_vc;
              end
              T_SINGLE: state_q <= S_IDLE;
              default:  pkt_err_q <= 1'b1;
            endcase
          end
          S_PKT: begin
            if (acc_vc != cur_vc_q) begin
              // Interleaving VC: flag it; a new head re-targets the checker
              pkt_err_q <= 1'b1;
              if (acc_type == T_HEAD) begin
                cur_vc_q <= acc_vc;
              end
            end else begin
              unique case (acc_type)
                T_BODY:  state_q <= S_PKT;
                T_TAIL:  state_q <= S_IDLE;
                default: pkt_err_q <= 1'b1;
              endcase
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_eject_buf.sv
// Directed self-checking bench for pe_eject_buf (DATA_W=32, DEPTH=4).
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
module tb_pe_eject_buf;

  localparam int DATA_W = 32;
  localparam int FW     = DATA_W + 2;

  logic              clk;
  logic              rst_;
  logic [1:0]        sel;
  logic [FW-1:0]     in_flit0;
  logic              in_valid0;
  logic [FW-1:0]     in_flit1;
  logic              in_valid1;
  logic [1:0]        in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_vc;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        credit;
  logic              pkt_err;

  int n_tests;
  int n_fail;

  pe_eject_buf #(.DATA_W(DATA_W), .DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .sel       (sel),
    .in_flit0  (in_flit0),
    .in_valid0 (in_valid0),
    .in_flit1  (in_flit1),
    .in_valid1 (in_valid1),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_vc    (out_vc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .credit    (credit),
    .pkt_err   (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel       = 2'b00;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_flit0  = '0;
    in_flit1  = '0;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    idle_inputs();
    tick();
    rst_ = 1'b0;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  logic [FW-1:0] v1_flits [6];
  logic [FW-1:0] q [$];
  int idx;
  int delivered;
  int credits1;
  int cyc;
  logic [FW-1:0] f_head, f_body, f_tail, f_single;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_      = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    f_head   = mk(2'b01, 32'hA000_0001);
    f_body   = mk(2'b00, 32'hA000_0002);
    f_tail   = mk(2'b10, 32'hA000_0003);
    f_single = mk(2'b11, 32'h5151_0042);
    v1_flits[0] = mk(2'b01, 32'hB000_0010);
    v1_flits[1] = mk(2'b00, 32'hB000_0011);
    v1_flits[2] = mk(2'b00, 32'hB000_0012);
    v1_flits[3] = mk(2'b00, 32'hB000_0013);
    v1_flits[4] = mk(2'b00, 32'hB000_0014);
    v1_flits[5] = mk(2'b10, 32'hB000_0015);
    tick();

    // 1: reset held two cycles while VC0 offers a flit
    sel = 2'b01; in_valid0 = 1'b1; in_flit0 = f_head; out_ready = 1'b1;
    tick();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_credit",    64'(credit),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_pkt_err",   64'(pkt_err),   64'd0);
    tick();
    rst_ = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // 2: VC0 head/body/tail with PE ready, one-cycle latency
    sel = 2'b01; in_valid0 = 1'b1; in_flit0 = f_head;
    #1;
    chk("t2_in_ready",  64'(in_ready),  64'd1);
    chk("t2_c0_valid",  64'(out_valid), 64'd0);
    chk("t2_c0_credit", 64'(credit),    64'd0);
    tick();
    in_flit0 = f_body;
    #1;
    chk("t2_c1_valid",  64'(out_valid), 64'd1);
    chk("t2_c1_flit",   64'(out_flit),  64'(f_head));
    chk("t2_c1_vc",     64'(out_vc),    64'd0);
    chk("t2_c1_credit", 64'(credit),    64'd1);
    tick();
    in_flit0 = f_tail;
    #1;
    chk("t2_c2_flit",   64'(out_flit),  64'(f_body));
    chk("t2_c2_credit", 64'(credit),    64'd1);
    tick();
    idle_inputs();
    #1;
    chk("t2_c3_flit",   64'(out_flit),  64'(f_tail));
    chk("t2_c3_vc",     64'(out_vc),    64'd0);
    chk("t2_c3_credit", 64'(credit),    64'd1);
    tick();
    #1;
    chk("t2_c4_valid",  64'(out_valid), 64'd0);
    chk("t2_c4_credit", 64'(credit),    64'd0);
    chk("t2_pkt_err",   64'(pkt_err),   64'd0);

    // 3: VC1 streams 6 flits into a 4-deep FIFO with PE stalled, then drains
    do_reset();
    idx = 0; delivered = 0; credits1 = 0; cyc = 0;
    q.delete();
    sel = 2'b10;
    while (delivered < 6 && cyc < 30) begin
      out_ready = (cyc >= 5);
      in_valid1 = (idx < 6);
      in_flit1  = (idx < 6) ? v1_flits[idx] : '0;
      #1;
      chk($sformatf("t3_in_ready_c%0d", cyc), 64'(in_ready),
          64'((q.size() < 4) ? 2'b10 : 2'b00));
      chk($sformatf("t3_valid_c%0d", cyc), 64'(out_valid), 64'(q.size() > 0));
      chk($sformatf("t3_credit_c%0d", cyc), 64'(credit),
          64'((q.size() > 0 && out_ready) ? 2'b10 : 2'b00));
      if (q.size() > 0) begin
        chk($sformatf("t3_flit_c%0d", cyc), 64'(out_flit), 64'(q[0]));
        chk($sformatf("t3_vc_c%0d", cyc), 64'(out_vc), 64'd1);
      end
      if (credit[1]) credits1++;
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        delivered++;
      end
      if (idx < 6 && q.size() + (delivered > 0 && out_ready ? 0 : 0) < 5 && in_ready[1]) begin
        q.push_back(v1_flits[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    chk("t3_delivered", 64'(delivered), 64'd6);
    chk("t3_credits",   64'(credits1),  64'd6);
    chk("t3_pkt_err",   64'(pkt_err),   64'd0);
    idle_inputs();

    // 4: head on VC0 then body from VC1 interleaves -> sticky error
    do_reset();
    out_ready = 1'b1;
    sel = 2'b01; in_valid0 = 1'b1; in_flit0 = f_head;
    tick();
    idle_inputs();
    sel = 2'b10; in_valid1 = 1'b1; in_flit1 = v1_flits[1];
    #1;
    chk("t4_err_before", 64'(pkt_err), 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("t4_err_set", 64'(pkt_err), 64'd1);
    tick();
    tick();
    chk("t4_err_sticky", 64'(pkt_err), 64'd1);

    // 5a: sel=11 with both VCs valid -> nothing accepted, error
    do_reset();
    out_ready = 1'b1;
    sel = 2'b11; in_valid0 = 1'b1; in_valid1 = 1'b1;
    in_flit0 = f_single; in_flit1 = f_single;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("t5_err",   64'(pkt_err),   64'd1);
    chk("t5_valid", 64'(out_valid), 64'd0);

    // 5b: reset mid-packet with 3 flits queued -> all discarded, no credits
    do_reset();
    #1;
    chk("t5_err_cleared", 64'(pkt_err), 64'd0);
    out_ready = 1'b0;
    sel = 2'b01; in_valid0 = 1'b1;
    in_flit0 = f_head; tick();
    in_flit0 = f_body; tick();
    in_flit0 = f_body; tick();
    idle_inputs();
    #1;
    chk("t5_queued_valid", 64'(out_valid), 64'd1);
    rst_ = 1'b1; out_ready = 1'b1; sel = 2'b01;
    #1;
    chk("t5_rst_valid",    64'(out_valid), 64'd0);
    chk("t5_rst_credit",   64'(credit),    64'd0);
    chk("t5_rst_in_ready", 64'(in_ready),  64'd0);
    tick();
    rst_ = 1'b0; sel = 2'b00;
    #1;
    chk("t5_after_valid0",  64'(out_valid), 64'd0);
    chk("t5_after_credit0", 64'(credit),    64'd0);
    tick();
    chk("t5_after_valid1",  64'(out_valid), 64'd0);
    chk("t5_after_credit1", 64'(credit),    64'd0);
    chk("t5_after_err",     64'(pkt_err),   64'd0);

    // 6: single flit into empty FIFO with PE ready
    do_reset();
    out_ready = 1'b1;
    sel = 2'b01; in_valid0 = 1'b1; in_flit0 = f_single;
    #1;
`ifdef PE_EJECT_BYPASS_EN
    chk("t6_acc_valid",  64'(out_valid), 64'd1);
    chk("t6_acc_credit", 64'(credit),    64'd1);
    chk("t6_acc_flit",   64'(out_flit),  64'(f_single));
    tick();
    idle_inputs();
    #1;
    chk("t6_next_valid", 64'(out_valid), 64'd0);
`else
    chk("t6_acc_valid",  64'(out_valid), 64'd0);
    chk("t6_acc_credit", 64'(credit),    64'd0);
    tick();
    idle_inputs();
    #1;
    chk("t6_next_valid",  64'(out_valid), 64'd1);
    chk("t6_next_credit", 64'(credit),    64'd1);
    chk("t6_next_flit",   64'(out_flit),  64'(f_single));
`endif
    chk("t6_pkt_err", 64'(pkt_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
